// File: rtl/calc_unit.sv
// calc_unit: multi-cycle arithmetic unit with valid/ready request and result
// handshakes. ADD/SUB/MUL (and DIV by zero) finish in one EXEC cycle. DIV with
// a nonzero divisor uses a restoring divider that takes WIDTH iteration cycles
// plus one cycle to register the result.
// Optional feature macro: CALC_DIV_EN builds the iterative divider. Without it,
// op 11 reports err with a zero result.
module calc_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
`ifdef CALC_DIV_EN
        , S_DIV = 2'd3
`endif
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, zero_q, err_q;

    logic             accept;

    // Single-cycle datapath results
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   ex_result;
    logic               ex_carry;
    logic               ex_err;

`ifdef CALC_DIV_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   sh;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic             div_last;
`endif

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

`ifdef CALC_DIV_EN
    // Restoring-division step: shift in the next dividend bit and subtract
    // the divisor when it fits. The partial remainder is always < b, so the
    // shifted value needs one extra bit but the difference fits in WIDTH bits.
    assign div_last = (cnt_q == CW'(WIDTH));
    always_comb begin
        sh      = {rem_q, quo_q[WIDTH-1]};
        q_bit   = (sh >= {1'b0, b_q});
        rem_nxt = q_bit ? (sh[WIDTH-1:0] - b_q) : sh[WIDTH-1:0];
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef CALC_DIV_EN
                    if (op == 2'b11 && b != '0) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_EXEC;
                    end
`else
                    state_d = S_EXEC;
`endif
                end
            end
            S_EXEC: state_d = S_DONE;
`ifdef CALC_DIV_EN
            S_DIV: begin
                if (div_last) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle operation results from the latched operands
    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        prod      = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        ex_result = '0;
        ex_carry  = 1'b0;
        ex_err    = 1'b0;
        case (op_q)
            2'b00: begin
                ex_result = sum[WIDTH-1:0];
                ex_carry  = sum[WIDTH];
            end
            2'b01: begin
                ex_result = a_q - b_q;
                ex_carry  = (a_q < b_q);
            end
            2'b10: begin
                ex_result = prod[WIDTH-1:0];
                ex_carry  = |prod[2*WIDTH-1:WIDTH];
            end
            default: begin
`ifdef CALC_DIV_EN
                // Only a zero divisor reaches EXEC with op 11.
                ex_result = '1;
`else
                ex_result = '0;
`endif
                ex_err    = 1'b1;
            end
        endcase
    end

    // Operand capture, divider iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef CALC_DIV_EN
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
`endif
        end else begin
            if (accept) begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
`ifdef CALC_DIV_EN
                cnt_q <= '0;
                rem_q <= '0;
                quo_q <= a;
`endif
            end
            if (state_q == S_EXEC) begin
                result_q <= ex_result;
                carry_q  <= ex_carry;
                zero_q   <= (ex_result == '0);
                err_q    <= ex_err;
            end
`ifdef CALC_DIV_EN
            if (state_q == S_DIV) begin
                if (!div_last) begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    result_q <= quo_q;
                    carry_q  <= (rem_q != '0);
                    zero_q   <= (quo_q == '0);
                    err_q    <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_calc_unit.sv
// Directed testbench for calc_unit at WIDTH=8. Expectations for op 11 follow
// whichever build of the divider (CALC_DIV_EN) is compiled.
module tb_calc_unit;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry, zero, err;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int vcount;

    calc_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one request and return #1 after the accept edge; operands are
    // scrambled afterwards to show the unit uses its latched copies.
    task automatic issue(input logic [1:0] o, input int x, input int y);
        int w;
        w = 0;
        while (!in_ready && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        op = o;
        a  = W'(x);
        b  = W'(y);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'($urandom);
        a  = W'($urandom);
        b  = W'($urandom);
    endtask

    // Count edges from accept until out_valid, bounded.
    task automatic wait_valid();
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input int x, input int y,
                       input int er, input int ec, input int ez, input int ee, input int el);
        out_ready = 1'b1;
        issue(o, x, y);
        wait_valid();
        chk({tag, ".lat"},    lat,    el);
        chk({tag, ".result"}, result, er);
        chk({tag, ".carry"},  carry,  ec);
        chk({tag, ".zero"},   zero,   ez);
        chk({tag, ".err"},    err,    ee);
        @(posedge clk); #1;
        chk({tag, ".in_ready"},  in_ready,  1);
        chk({tag, ".out_valid"}, out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  in_ready,  0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result",    result,    0);
        chk("rst.carry",     carry,     0);
        chk("rst.zero",      zero,      0);
        chk("rst.err",       err,       0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.in_ready", in_ready, 1);

        run("add_200_100", 2'b00, 200, 100,  44, 1, 0, 0, 1);
        run("add_255_1",   2'b00, 255,   1,   0, 1, 1, 0, 1);
        run("sub_5_9",     2'b01,   5,   9, 252, 1, 0, 0, 1);
        run("sub_9_9",     2'b01,   9,   9,   0, 0, 1, 0, 1);
        run("mul_16_17",   2'b10,  16,  17,  16, 1, 0, 0, 1);
        run("mul_15_17",   2'b10,  15,  17, 255, 0, 0, 0, 1);
`ifdef CALC_DIV_EN
        run("div_200_7",   2'b11, 200,   7,  28, 1, 0, 0, 9);
        run("div_200_0",   2'b11, 200,   0, 255, 0, 0, 1, 1);
        run("div_7_200",   2'b11,   7, 200,   0, 1, 1, 0, 9);
        run("div_255_1",   2'b11, 255,   1, 255, 0, 0, 0, 9);
`else
        run("div_200_7",   2'b11, 200,   7,   0, 0, 1, 1, 1);
        run("div_200_0",   2'b11, 200,   0,   0, 0, 1, 1, 1);
`endif

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        issue(2'b00, 3, 4);
        wait_valid();
        chk("bp.lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.out_valid", out_valid, 1);
            chk("bp.result",    result,    7);
            chk("bp.carry",     carry,     0);
            chk("bp.in_ready",  in_ready,  0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release.in_ready",  in_ready,  1);
        chk("bp.release.out_valid", out_valid, 0);

        // Reset during a DIV (or a held result when the divider is absent)
        out_ready = 1'b0;
        issue(2'b11, 200, 7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.in_ready_hi", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.result",    result,    0);
        chk("midrst.carry",     carry,     0);
        chk("midrst.zero",      zero,      0);
        chk("midrst.err",       err,       0);
        chk("midrst.in_ready",  in_ready,  1);
        out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) vcount++;
        end
        chk("midrst.no_pulse", vcount, 0);
        run("add_1_1", 2'b00, 1, 1, 2, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
